// File: rtl/wishbone_slave_ram_pkg.sv
// Shared widths, FSM encoding and request record for the board-memory responder.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package wishbone_slave_ram_pkg;

  localparam int WB_ADR_W = 8;
  localparam int WB_DAT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_CLEAR
  } slave_state_t;

  // One captured bus request: direction, word address, write data.
  typedef struct packed {
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
  } wb_req_t;

  // True when the word address maps onto a physical memory word.
  function automatic logic adr_in_range(input logic [WB_ADR_W-1:0] adr, input int depth);
    return 32'(adr) < 32'(depth);
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Single-word Wishbone link between the game master and the board memory.
// Latency: n/a (wires only).
// Backpressure: slave raises stall_o while it cannot accept; ack_o terminates a cycle.
interface wishbone_if;
  import wishbone_slave_ram_pkg::*;

  logic                cyc_i;
  logic                stb_i;
  logic                we_i;
  logic [WB_ADR_W-1:0] adr_i;
  logic [WB_DAT_W-1:0] dat_i;
  logic                ack_o;
  logic                stall_o;
  logic [WB_DAT_W-1:0] dat_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output ack_o, stall_o, dat_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  ack_o, stall_o, dat_o
  );

endinterface

// File: rtl/wb_slave_mem.sv
// Simple dual-port board RAM: port A sync write + gated sync read, port B sync read.
// Latency: 1 cycle on both read ports; a_rdata holds between read enables.
// Backpressure: none; always accepts. Array has no reset so it maps onto block RAM.
//
// Ports:
//   clk                      clock
//   a_we / a_re              port A write enable / read enable
//   a_addr, a_wdata, a_rdata port A address, write data, registered read data
//   b_addr, b_rdata          port B address, registered read data (old data on collision)
module wb_slave_mem
  import wishbone_slave_ram_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                clk,
  input  logic                a_we,
  input  logic                a_re,
  input  logic [WB_ADR_W-1:0] a_addr,
  input  logic [WB_DAT_W-1:0] a_wdata,
  output logic [WB_DAT_W-1:0] a_rdata,
  input  logic [WB_ADR_W-1:0] b_addr,
  output logic [WB_DAT_W-1:0] b_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WB_DAT_W-1:0] mem [DEPTH];
  logic [AW-1:0]       a_idx;
  logic [AW-1:0]       b_idx;

  // Callers guarantee in-range addresses for writes and mask read data
  // for out-of-range addresses, so only the low bits index the array.
  assign a_idx = a_addr[AW-1:0];
  assign b_idx = b_addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_idx] <= a_wdata;
    end
    if (a_re) begin
      a_rdata <= mem[a_idx];
    end
    b_rdata <= mem[b_idx];
  end

endmodule

// File: rtl/wishbone_slave_ram.sv
// Wishbone responder over the 16-bit board memory, with display read port and bulk clear.
// Latency: ack one cycle after stb sampled plus WAIT_STATES; display data one cycle.
// Backpressure: stall_o high during wait states and the clear sweep; requests stay pending.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clear_req      one-cycle pulse starting the zeroing sweep (wins over a bus request)
//   clear_busy     high for DEPTH cycles while the sweep runs
//   disp_addr      display read address
//   disp_data      display read data, 1-cycle latency, 0 when out of range
//   wb_slave       Wishbone slave modport
module wishbone_slave_ram
  import wishbone_slave_ram_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_req,
  output logic                clear_busy,
  input  logic [WB_ADR_W-1:0] disp_addr,
  output logic [WB_DAT_W-1:0] disp_data,
  wishbone_if.slave           wb_slave
);

  // WAIT_LAST is only compared while in S_WAIT, which WAIT_STATES=0 never enters.
  localparam logic [2:0]          WAIT_LAST = 3'(WAIT_STATES - 1);
  localparam logic [WB_ADR_W-1:0] CLR_LAST  = WB_ADR_W'(DEPTH - 1);

  slave_state_t        state;
  logic [2:0]          wait_cnt;
  logic [WB_ADR_W-1:0] clr_cnt;
  wb_req_t             req_q;
  logic                ack_q;
  logic                stall_q;
  logic                rd_oor_q;
  logic                disp_oor_q;

  logic                bus_req;
  wb_req_t             cmt;
  logic                commit;
  logic                mem_we;
  logic                mem_re;
  logic [WB_ADR_W-1:0] mem_addr;
  logic [WB_DAT_W-1:0] mem_wdata;
  logic [WB_DAT_W-1:0] mem_rdata;
  logic [WB_DAT_W-1:0] disp_rdata;

  assign bus_req = wb_slave.cyc_i & wb_slave.stb_i;

  // With no wait states the request commits on the same edge it is sampled,
  // so it must come straight from the bus rather than the latched copy.
  assign cmt = (state == S_IDLE) ? {wb_slave.we_i, wb_slave.adr_i, wb_slave.dat_i} : req_q;

  // commit marks the edge that enters S_ACK: the write lands and read data is captured.
  always_comb begin
    commit = 1'b0;
    if (state == S_IDLE) begin
      commit = !clear_req && bus_req && (WAIT_STATES == 0);
    end else if (state == S_WAIT) begin
      commit = wb_slave.cyc_i && (wait_cnt == WAIT_LAST);
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = cmt.adr;
    mem_wdata = cmt.dat;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = '0;
    end else if (commit) begin
      mem_we = cmt.we && adr_in_range(cmt.adr, DEPTH);
      mem_re = !cmt.we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      clr_cnt    <= '0;
      req_q      <= '0;
      ack_q      <= 1'b0;
      stall_q    <= 1'b0;
      clear_busy <= 1'b0;
      // The RAM read registers are not reset; forcing the out-of-range
      // flags makes dat_o and disp_data read as zero until first use.
      rd_oor_q   <= 1'b1;
      disp_oor_q <= 1'b1;
    end else begin
      disp_oor_q <= !adr_in_range(disp_addr, DEPTH);
      if (commit && !cmt.we) begin
        rd_oor_q <= !adr_in_range(cmt.adr, DEPTH);
      end

      case (state)
        S_IDLE: begin
          if (clear_req) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            clear_busy <= 1'b1;
            stall_q    <= 1'b1;
          end else if (bus_req) begin
            req_q <= cmt;
            if (WAIT_STATES == 0) begin
              state <= S_ACK;
              ack_q <= 1'b1;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= '0;
              stall_q  <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (!wb_slave.cyc_i) begin
            // Master abandoned the cycle: no ack, nothing written.
            state   <= S_IDLE;
            stall_q <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= S_ACK;
            stall_q <= 1'b0;
            ack_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        S_ACK: begin
          state <= S_IDLE;
          ack_q <= 1'b0;
        end

        S_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            state      <= S_IDLE;
            clear_busy <= 1'b0;
            stall_q    <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + WB_ADR_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign wb_slave.ack_o   = ack_q;
  assign wb_slave.stall_o = stall_q;
  assign wb_slave.dat_o   = rd_oor_q ? '0 : mem_rdata;
  assign disp_data        = disp_oor_q ? '0 : disp_rdata;

  wb_slave_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .a_we    (mem_we),
    .a_re    (mem_re),
    .a_addr  (mem_addr),
    .a_wdata (mem_wdata),
    .a_rdata (mem_rdata),
    .b_addr  (disp_addr),
    .b_rdata (disp_rdata)
  );

endmodule

// File: tb/tb_wishbone_slave_ram.sv
// Bench for wishbone_slave_ram: dut0 (DEPTH 256, no wait states), dut1 (DEPTH 64, 3 wait states).
// Drivers push expected responses into per-DUT queues; a negedge monitor pops on every ack.
// Reference memory is a plain array updated in program order.
module tb_wishbone_slave_ram;

  typedef struct {
    bit          rd;
    logic [15:0] exp;
    bit          after_clr;
    int          exp_cyc;
    int          exp_stall;
  } ent_t;

  logic clk;
  logic rst_n;
  int   cnt;
  int   checks;
  int   errors;

  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [7:0]  adr   [2];
  logic [15:0] wdat  [2];
  logic        clr   [2];
  logic [7:0]  daddr [2];

  logic        ack_w   [2];
  logic        stall_w [2];
  logic [15:0] dat_w   [2];
  logic        busy_w  [2];
  logic [15:0] disp_w  [2];

  logic        busy0, busy1;
  logic [15:0] disp0, disp1;

  logic [15:0] mdl [2][256];
  ent_t        q0 [$];
  ent_t        q1 [$];

  int          stall_run [2];
  int          busy_run  [2];
  int          last_busy [2];
  logic        prev_ack  [2];
  logic [15:0] last_rd   [2];

  wishbone_if wb0 ();
  wishbone_if wb1 ();

  assign wb0.cyc_i = cyc[0];  assign wb1.cyc_i = cyc[1];
  assign wb0.stb_i = stb[0];  assign wb1.stb_i = stb[1];
  assign wb0.we_i  = we[0];   assign wb1.we_i  = we[1];
  assign wb0.adr_i = adr[0];  assign wb1.adr_i = adr[1];
  assign wb0.dat_i = wdat[0]; assign wb1.dat_i = wdat[1];

  assign ack_w[0]   = wb0.ack_o;   assign ack_w[1]   = wb1.ack_o;
  assign stall_w[0] = wb0.stall_o; assign stall_w[1] = wb1.stall_o;
  assign dat_w[0]   = wb0.dat_o;   assign dat_w[1]   = wb1.dat_o;
  assign busy_w[0]  = busy0;       assign busy_w[1]  = busy1;
  assign disp_w[0]  = disp0;       assign disp_w[1]  = disp1;

  wishbone_slave_ram #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clr[0]),
    .clear_busy (busy0),
    .disp_addr  (daddr[0]),
    .disp_data  (disp0),
    .wb_slave   (wb0)
  );

  wishbone_slave_ram #(.DEPTH(64), .WAIT_STATES(3)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clr[1]),
    .clear_busy (busy1),
    .disp_addr  (daddr[1]),
    .disp_data  (disp1),
    .wb_slave   (wb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  function automatic int dep(input int s);
    return (s == 0) ? 256 : 64;
  endfunction

  function automatic int ws(input int s);
    return (s == 0) ? 0 : 3;
  endfunction

  function automatic logic [15:0] mdl_rd(input int s, input logic [7:0] a);
    return (int'(a) < dep(s)) ? mdl[s][a] : 16'h0000;
  endfunction

  task automatic chk(input string nm, input int s, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h want %0h (cycle %0d)", s, nm, act, exp, cnt);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int s);
    ent_t e;
    bit   have;
    have = 1'b0;
    if (ack_w[s] === 1'b1) begin
      chk("ack width", s, 32'(prev_ack[s]), 0);
      chk("stall at ack", s, 32'(stall_w[s]), 0);
      if (s == 0) begin
        if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
      end else begin
        if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
      end
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL dut%0d unexpected ack: got ack=1 want no ack (cycle %0d)", s, cnt);
      end else begin
        if (e.after_clr) begin
          chk("ack after clear", s, cnt, last_busy[s] + 2);
        end else begin
          chk("ack latency", s, cnt, e.exp_cyc);
          chk("stall cycles", s, stall_run[s], e.exp_stall);
        end
        if (e.rd) begin
          chk("read data", s, 32'(dat_w[s]), 32'(e.exp));
          last_rd[s] = e.exp;
        end else begin
          chk("dat_o hold", s, 32'(dat_w[s]), 32'(last_rd[s]));
        end
      end
      stall_run[s] = 0;
    end else if (stall_w[s] === 1'b1 && busy_w[s] !== 1'b1) begin
      stall_run[s]++;
    end else begin
      stall_run[s] = 0;
    end

    if (busy_w[s] === 1'b1) begin
      busy_run[s]++;
      last_busy[s] = cnt;
    end else if (busy_run[s] != 0) begin
      chk("clear length", s, busy_run[s], dep(s));
      busy_run[s] = 0;
    end
    prev_ack[s] = ack_w[s];
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) mon(s);
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_start(input int s, input bit w, input logic [7:0] a,
                           input logic [15:0] d, input bit after_clr);
    ent_t e;
    e.rd        = !w;
    e.exp       = w ? 16'h0000 : mdl_rd(s, a);
    e.after_clr = after_clr;
    e.exp_cyc   = cnt + 1 + ws(s);
    e.exp_stall = ws(s);
    if (w && int'(a) < dep(s)) mdl[s][a] = d;
    if (s == 0) q0.push_back(e); else q1.push_back(e);
    cyc[s] = 1'b1; stb[s] = 1'b1; we[s] = w; adr[s] = a; wdat[s] = d;
  endtask

  // Holds the strobe until ack is seen, then drops it on the following edge.
  task automatic bus_finish(input int s);
    int n;
    n = 0;
    while (ack_w[s] !== 1'b1 && n < 1000) begin tick(); n++; end
    if (ack_w[s] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL dut%0d ack timeout: got no ack want ack within 1000 cycles", s);
    end
    tick();
    cyc[s] = 1'b0; stb[s] = 1'b0; we[s] = 1'b0;
  endtask

  task automatic bus_xfer(input int s, input bit w, input logic [7:0] a, input logic [15:0] d);
    bus_start(s, w, a, d, 1'b0);
    bus_finish(s);
  endtask

  task automatic clear_pulse(input int s);
    clr[s] = 1'b1;
    for (int i = 0; i < dep(s); i++) mdl[s][i] = 16'h0000;
    tick();
    clr[s] = 1'b0;
  endtask

  task automatic wait_clear(input int s);
    int n;
    n = 0;
    while (busy_w[s] === 1'b1 && n < 400) begin tick(); n++; end
    if (busy_w[s] === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL dut%0d clear timeout: got busy=1 want busy=0", s);
    end
  endtask

  task automatic disp_chk(input int s, input logic [7:0] a);
    daddr[s] = a;
    tick();
    chk("display", s, 32'(disp_w[s]), 32'(mdl_rd(s, a)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] old;
    checks = 0;
    errors = 0;
    for (int s = 0; s < 2; s++) begin
      cyc[s] = 0; stb[s] = 0; we[s] = 0; adr[s] = 0; wdat[s] = 0; clr[s] = 0; daddr[s] = 0;
      stall_run[s] = 0; busy_run[s] = 0; last_busy[s] = 0; prev_ack[s] = 0; last_rd[s] = 0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset ack", s, 32'(ack_w[s]), 0);
      chk("reset stall", s, 32'(stall_w[s]), 0);
      chk("reset dat_o", s, 32'(dat_w[s]), 0);
      chk("reset busy", s, 32'(busy_w[s]), 0);
      chk("reset disp", s, 32'(disp_w[s]), 0);
    end
    rst_n = 1'b1;
    tick();

    // Bring both memories to a known all-zero state.
    clear_pulse(0);
    clear_pulse(1);
    wait_clear(0);
    wait_clear(1);

    // Basic write/read, zero wait states.
    bus_xfer(0, 1'b1, 8'h05, 16'h1234);
    bus_xfer(0, 1'b0, 8'h05, 16'h0000);
    disp_chk(0, 8'h05);

    // Wait-state reads and writes.
    bus_xfer(1, 1'b0, 8'h10, 16'h0000);
    bus_xfer(1, 1'b1, 8'h10, 16'h1111);
    bus_xfer(1, 1'b0, 8'h10, 16'h0000);
    repeat (4) tick();

    // Fill, clear, read everything back.
    for (int i = 0; i < 256; i++) bus_xfer(0, 1'b1, 8'(i), 16'hFFFF);
    clear_pulse(0);
    wait_clear(0);
    for (int i = 0; i < 256; i++) bus_xfer(0, 1'b0, 8'(i), 16'h0000);

    // Write pending through a clear, with a second ignored clear pulse.
    clear_pulse(0);
    repeat (5) tick();
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    bus_start(0, 1'b1, 8'h33, 16'hBEEF, 1'b1);
    bus_finish(0);
    bus_xfer(0, 1'b0, 8'h33, 16'h0000);

    // Clear and bus request in the same cycle: clear wins, request waits.
    for (int i = 0; i < 256; i++) mdl[0][i] = 16'h0000;
    clr[0] = 1'b1;
    bus_start(0, 1'b1, 8'h44, 16'hCAFE, 1'b1);
    tick();
    clr[0] = 1'b0;
    bus_finish(0);
    bus_xfer(0, 1'b0, 8'h44, 16'h0000);
    bus_xfer(0, 1'b0, 8'h33, 16'h0000);

    // Out-of-range on the 64-word instance.
    bus_xfer(1, 1'b1, 8'h50, 16'hAAAA);
    bus_xfer(1, 1'b0, 8'h50, 16'h0000);
    bus_xfer(1, 1'b0, 8'h10, 16'h0000);
    disp_chk(1, 8'h50);
    disp_chk(1, 8'h10);

    // Reset during the wait states of a write.
    bus_xfer(1, 1'b1, 8'h20, 16'h7777);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h20; wdat[1] = 16'h5555;
    tick();
    tick();
    chk("stall in wait", 1, 32'(stall_w[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("reset drops ack", 1, 32'(ack_w[1]), 0);
    chk("reset drops stall", 1, 32'(stall_w[1]), 0);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    tick();
    rst_n = 1'b1;
    tick();
    disp_chk(1, 8'h20);
    bus_xfer(1, 1'b0, 8'h20, 16'h0000);

    // Master drops cyc during wait states: no ack, no write.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h21; wdat[1] = 16'h9999;
    tick();
    tick();
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    repeat (3) tick();
    bus_xfer(1, 1'b0, 8'h21, 16'h0000);

    // Display sees old data when a write hits the same word on the same edge.
    bus_xfer(0, 1'b1, 8'h40, 16'h1357);
    daddr[0] = 8'h40;
    tick();
    old = mdl[0][8'h40];
    bus_start(0, 1'b1, 8'h40, 16'h2468, 1'b0);
    tick();
    chk("display collision", 0, 32'(disp_w[0]), 32'(old));
    bus_finish(0);
    disp_chk(0, 8'h40);

    // Randomised traffic on both instances.
    for (int k = 0; k < 80; k++) begin
      int          s;
      bit          w;
      logic [7:0]  a;
      logic [15:0] d;
      s = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = (s == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 127));
      d = 16'($urandom);
      bus_xfer(s, w, a, d);
      if ($urandom_range(0, 3) == 0) disp_chk(s, 8'($urandom_range(0, 255)));
    end

    repeat (5) tick();
    chk("queue drained", 0, q0.size(), 0);
    chk("queue drained", 1, q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
